// File: rtl/nn_img_bf_ctrl.sv
// Image buffer sequencer: loads a word stream into addresses 0..N-1, then
// replays a rectangular window to the PE array as a valid/last pixel stream.
module nn_img_bf_ctrl #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6,
    parameter int DIM_WIDTH        = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH:0]         i_load_len,
    input  logic [ADDR_WIDTH-1:0]       i_rd_base,
    input  logic [DIM_WIDTH-1:0]        i_rd_rows,
    input  logic [DIM_WIDTH-1:0]        i_rd_cols,
    input  logic [ADDR_WIDTH-1:0]       i_rd_pitch,
    input  logic                        i_in_valid,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_in_data,
    output logic                        o_in_ready,
    input  logic                        i_pe_stall,
    output logic                        o_bf_wr_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
    output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
    output logic                        o_bf_rd_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data,
    output logic                        o_px_valid,
    output logic [TOTAL_DATA_WIDTH-1:0] o_px_data,
    output logic                        o_px_last,
    output logic                        o_busy,
    output logic                        o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;
    localparam logic [ADDR_WIDTH:0]  LEN_ONE = 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     load_len_q, load_len_d;
    logic [ADDR_WIDTH:0]     wcnt_q, wcnt_d;
    logic [DIM_WIDTH-1:0]    rows_q, rows_d;
    logic [DIM_WIDTH-1:0]    cols_q, cols_d;
    logic [DIM_WIDTH-1:0]    r_q, r_d;
    logic [DIM_WIDTH-1:0]    c_q, c_d;
    logic [ADDR_WIDTH-1:0]   pitch_q, pitch_d;
    logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
    logic                    px_valid_q, px_valid_d;
    logic                    px_last_q, px_last_d;

    logic                    c_last;
    logic                    last_elem;
    logic                    window_empty;

    assign c_last       = (c_q == cols_q - DIM_ONE);
    assign last_elem    = c_last && (r_q == rows_q - DIM_ONE);
    assign window_empty = (rows_q == '0) || (cols_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            load_len_q <= '0;
            wcnt_q     <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            pitch_q    <= '0;
            row_addr_q <= '0;
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_len_q <= load_len_d;
            wcnt_q     <= wcnt_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            r_q        <= r_d;
            c_q        <= c_d;
            pitch_q    <= pitch_d;
            row_addr_q <= row_addr_d;
            px_valid_q <= px_valid_d;
            px_last_q  <= px_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_len_d = load_len_q;
        wcnt_d     = wcnt_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        r_d        = r_q;
        c_d        = c_q;
        pitch_d    = pitch_q;
        row_addr_d = row_addr_q;
        // The pixel pipe mirrors read issue one cycle later, so a stall never drops an in-flight word.
        px_valid_d = o_bf_rd_en;
        px_last_d  = o_bf_rd_en && last_elem;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    load_len_d = i_load_len;
                    rows_d     = i_rd_rows;
                    cols_d     = i_rd_cols;
                    pitch_d    = i_rd_pitch;
                    row_addr_d = i_rd_base;
                    wcnt_d     = '0;
                    r_d        = '0;
                    c_d        = '0;
                    if (i_load_len != '0)
                        state_d = S_LOAD;
                    else if ((i_rd_rows != '0) && (i_rd_cols != '0))
                        state_d = S_READ;
                    else
                        state_d = S_DONE;
                end
            end
            S_LOAD: begin
                if (o_bf_wr_en) begin
                    wcnt_d = wcnt_q + LEN_ONE;
                    if (wcnt_q == load_len_q - LEN_ONE)
                        state_d = window_empty ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (o_bf_rd_en) begin
                    if (c_last) begin
                        c_d        = '0;
                        r_d        = r_q + DIM_ONE;
                        row_addr_d = row_addr_q + pitch_q;
                    end else begin
                        c_d = c_q + DIM_ONE;
                    end
                    if (last_elem)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready   = (state_q == S_LOAD);
        o_bf_wr_en   = (state_q == S_LOAD) && i_in_valid;
        o_bf_wr_addr = o_bf_wr_en ? wcnt_q[ADDR_WIDTH-1:0] : '0;
        o_bf_wr_data = o_bf_wr_en ? i_in_data : '0;
        o_bf_rd_en   = (state_q == S_READ) && !i_pe_stall;
        o_bf_rd_addr = (state_q == S_READ) ? (row_addr_q + ADDR_WIDTH'(c_q)) : '0;
        o_px_valid   = px_valid_q;
        o_px_last    = px_last_q;
        o_px_data    = i_bf_rd_data;
        o_busy       = (state_q != S_IDLE);
        o_done       = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_nn_img_bf_ctrl.sv
// Bench for nn_img_bf_ctrl: random load streams and windows checked against
// a queue-based model of expected writes, read addresses and pixels.
module tb_nn_img_bf_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int TW    = DW * 6;
    localparam int MW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic [AW:0]   i_load_len;
    logic [AW-1:0] i_rd_base;
    logic [MW-1:0] i_rd_rows;
    logic [MW-1:0] i_rd_cols;
    logic [AW-1:0] i_rd_pitch;
    logic          i_in_valid;
    logic [TW-1:0] i_in_data;
    logic          o_in_ready;
    logic          i_pe_stall;
    logic          o_bf_wr_en;
    logic [AW-1:0] o_bf_wr_addr;
    logic [TW-1:0] o_bf_wr_data;
    logic          o_bf_rd_en;
    logic [AW-1:0] o_bf_rd_addr;
    logic [TW-1:0] i_bf_rd_data;
    logic          o_px_valid;
    logic [TW-1:0] o_px_data;
    logic          o_px_last;
    logic          o_busy;
    logic          o_done;

    nn_img_bf_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW), .DIM_WIDTH(MW)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_load_len(i_load_len),
        .i_rd_base(i_rd_base), .i_rd_rows(i_rd_rows), .i_rd_cols(i_rd_cols),
        .i_rd_pitch(i_rd_pitch), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .i_pe_stall(i_pe_stall), .o_bf_wr_en(o_bf_wr_en),
        .o_bf_wr_addr(o_bf_wr_addr), .o_bf_wr_data(o_bf_wr_data), .o_bf_rd_en(o_bf_rd_en),
        .o_bf_rd_addr(o_bf_rd_addr), .i_bf_rd_data(i_bf_rd_data), .o_px_valid(o_px_valid),
        .o_px_data(o_px_data), .o_px_last(o_px_last), .o_busy(o_busy), .o_done(o_done)
    );

    // ---------------- clock / reset / environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous buffer with 1-cycle read latency (the DUT's environment).
    logic [TW-1:0] mem [DEPTH];
    logic          mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            i_bf_rd_data <= '0;
        end else begin
            if (o_bf_wr_en) mem[o_bf_wr_addr] <= o_bf_wr_data;
            if (o_bf_rd_en) i_bf_rd_data <= mem[o_bf_rd_addr];
        end
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;

    logic [AW-1:0] exp_wa_q[$];
    logic [TW-1:0] exp_wd_q[$];
    logic [AW-1:0] exp_ra_q[$];
    logic [TW-1:0] exp_px_q[$];
    int            rd_cyc_q[$];

    logic [TW-1:0] ref_mem   [DEPTH];
    logic [TW-1:0] job_words [DEPTH];

    bit mon_en = 0;
    bit in_job = 0;
    int wr_cnt = 0, rd_cnt = 0, px_cnt = 0, done_cnt = 0;
    int last_rd_cyc = 0, last_px_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_rd_exclusive", 64'(o_bf_wr_en & o_bf_rd_en), 0);
            chk("wr_en_rule", 64'(o_bf_wr_en), 64'(i_in_valid & o_in_ready));
            if (o_in_ready) chk("ready_only_in_load", 64'(exp_wa_q.size() != 0), 1);
            if (o_bf_wr_en) begin
                chk("wr_pending", 64'(exp_wa_q.size() != 0), 1);
                if (exp_wa_q.size() != 0) begin
                    chk("wr_addr", 64'(o_bf_wr_addr), 64'(exp_wa_q.pop_front()));
                    chk("wr_data", 64'(o_bf_wr_data), 64'(exp_wd_q.pop_front()));
                end
                wr_cnt++;
            end
            if (o_bf_rd_en) begin
                chk("rd_while_stall", 64'(i_pe_stall), 0);
                chk("rd_pending", 64'(exp_ra_q.size() != 0), 1);
                if (exp_ra_q.size() != 0)
                    chk("rd_addr", 64'(o_bf_rd_addr), 64'(exp_ra_q.pop_front()));
                rd_cnt++;
                last_rd_cyc = cyc;
                rd_cyc_q.push_back(cyc);
            end
            if (o_px_valid) begin
                chk("px_pending", 64'(exp_px_q.size() != 0), 1);
                if (exp_px_q.size() != 0)
                    chk("px_data", 64'(o_px_data), 64'(exp_px_q.pop_front()));
                chk("px_last", 64'(o_px_last), 64'(exp_px_q.size() == 0));
                px_cnt++;
                last_px_cyc = cyc;
            end else begin
                chk("px_last_idle", 64'(o_px_last), 0);
            end
            if (o_done) begin
                chk("done_queues_empty",
                    64'(exp_wa_q.size() + exp_ra_q.size() + exp_px_q.size()), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_job) chk("busy_in_job", 64'(o_busy), 1);
        end
    end

    // ---------------- model ----------------
    task automatic build_model(input int len, input int base, input int rows,
                               input int cols, input int pitch, input int dmode);
        logic [TW-1:0] w;
        int a;
        for (int i = 0; i < len; i++) begin
            case (dmode)
                1:       w = TW'(i);
                2:       w = TW'(32'hA0 + i);
                default: w = TW'({$urandom(), $urandom()});
            endcase
            job_words[i] = w;
            ref_mem[i]   = w;
            exp_wa_q.push_back(AW'(i));
            exp_wd_q.push_back(w);
        end
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                a = (base + r * pitch + c) % DEPTH;
                exp_ra_q.push_back(AW'(a));
                exp_px_q.push_back(ref_mem[a]);
            end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        i_start    = 0;
        i_in_valid = 0;
        i_pe_stall = 0;
    endtask

    task automatic randomize_cfg();
        i_load_len = (AW + 1)'($urandom());
        i_rd_base  = AW'($urandom());
        i_rd_rows  = MW'($urandom());
        i_rd_cols  = MW'($urandom());
        i_rd_pitch = AW'($urandom());
    endtask

    task automatic launch_job(input int len, input int base, input int rows, input int cols,
                              input int pitch, input int smode, input bit consec);
        int n, px0, rd0, dn0, wr0, t, idx, stall_left;
        bit got;
        n = rows * cols;
        px0 = px_cnt; rd0 = rd_cnt; dn0 = done_cnt; wr0 = wr_cnt;
        rd_cyc_q.delete();
        @(posedge clk); #1;
        i_start    = 1;
        i_load_len = (AW + 1)'(len);
        i_rd_base  = AW'(base);
        i_rd_rows  = MW'(rows);
        i_rd_cols  = MW'(cols);
        i_rd_pitch = AW'(pitch);
        @(posedge clk); #1;
        i_start = 0;
        in_job  = 1;
        randomize_cfg();
        t = 0; got = 0; stall_left = 3;
        while (!got && t < 4000) begin
            idx = wr_cnt - wr0;
            i_in_valid = ($urandom_range(0, 9) < 7);
            i_in_data  = (idx < len) ? job_words[idx] : TW'({$urandom(), $urandom()});
            case (smode)
                1: begin
                    if ((rd_cnt - rd0) >= 2 && stall_left > 0) begin
                        i_pe_stall = 1;
                        stall_left--;
                    end else begin
                        i_pe_stall = 0;
                    end
                end
                2:       i_pe_stall = ($urandom_range(0, 9) < 3);
                default: i_pe_stall = 0;
            endcase
            i_start = (t == 3);
            @(posedge clk); #1;
            t++;
            got = (done_cnt != dn0);
        end
        drive_idle();
        in_job = 0;
        chk("job_timeout", 64'(got), 1);
        chk("wr_total", 64'(wr_cnt - wr0), 64'(len));
        chk("rd_total", 64'(rd_cnt - rd0), 64'(n));
        chk("px_total", 64'(px_cnt - px0), 64'(n));
        chk("done_pulses", 64'(done_cnt - dn0), 1);
        if (n > 0) begin
            chk("px_one_after_rd", 64'(last_px_cyc - last_rd_cyc), 1);
            chk("done_one_after_last_px", 64'(done_cyc - last_px_cyc), 1);
            if (consec && rd_cyc_q.size() == n)
                chk("rd_consecutive", 64'(rd_cyc_q[$] - rd_cyc_q[0]), 64'(n - 1));
        end
        @(negedge clk);
        chk("idle_after_done", 64'(o_busy), 0);
        chk("done_single_cycle", 64'(o_done), 0);
    endtask

    // ---------------- main sequence ----------------
    int str_addr [6];
    int wrap_addr[4];

    initial begin
        str_addr  = '{5, 6, 9, 10, 13, 14};
        wrap_addr = '{1022, 1023, 0, 1};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        mem_clr = 1;
        i_rst = 1;
        drive_idle();
        i_in_data = '0;
        randomize_cfg();

        // Reset held for two cycles: every output must sit at its reset value.
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", 64'(o_busy), 0);
            chk("rst_done", 64'(o_done), 0);
            chk("rst_px_valid", 64'(o_px_valid), 0);
            chk("rst_px_last", 64'(o_px_last), 0);
            chk("rst_rd_en", 64'(o_bf_rd_en), 0);
            chk("rst_wr_en", 64'(o_bf_wr_en), 0);
            chk("rst_in_ready", 64'(o_in_ready), 0);
            chk("rst_addrs", 64'({o_bf_wr_addr, o_bf_rd_addr}), 0);
            chk("rst_wr_data", 64'(o_bf_wr_data), 0);
        end
        @(posedge clk); #1;
        i_rst = 0;
        mem_clr = 0;
        i_in_valid = 1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_no_write", 64'(o_bf_wr_en), 0);
            chk("idle_not_ready", 64'(o_in_ready), 0);
        end
        drive_idle();
        mon_en = 1;

        // Four words with gaps, 2x2 window over addresses 0..3.
        build_model(4, 0, 2, 2, 2, 2);
        chk("pin_px0", 64'(exp_px_q[0]), 64'h0A0);
        chk("pin_px3", 64'(exp_px_q[3]), 64'h0A3);
        chk("pin_ra3", 64'(exp_ra_q[3]), 3);
        launch_job(4, 0, 2, 2, 2, 0, 1);

        // Strided window, then the same job with a scripted 3-cycle stall.
        build_model(16, 5, 3, 2, 4, 1);
        for (int i = 0; i < 6; i++) begin
            chk("pin_stride_addr", 64'(exp_ra_q[i]), 64'(str_addr[i]));
            chk("pin_stride_px", 64'(exp_px_q[i]), 64'(str_addr[i]));
        end
        launch_job(16, 5, 3, 2, 4, 0, 1);
        build_model(16, 5, 3, 2, 4, 1);
        launch_job(16, 5, 3, 2, 4, 1, 0);

        // Degenerate windows and address wrap.
        build_model(0, 3, 1, 1, 0, 1);
        chk("pin_single_addr", 64'(exp_ra_q[0]), 3);
        launch_job(0, 3, 1, 1, 0, 0, 1);
        build_model(0, 3, 0, 3, 0, 1);
        launch_job(0, 3, 0, 3, 0, 0, 1);
        build_model(0, 1022, 1, 4, 0, 1);
        for (int i = 0; i < 4; i++)
            chk("pin_wrap_addr", 64'(exp_ra_q[i]), 64'(wrap_addr[i]));
        launch_job(0, 1022, 1, 4, 0, 0, 1);

        // Abort in READ after two pixels, then a normal job.
        begin
            int px0, t;
            build_model(0, 0, 4, 4, 4, 1);
            px0 = px_cnt;
            @(posedge clk); #1;
            i_start = 1; i_load_len = '0; i_rd_base = '0;
            i_rd_rows = 4; i_rd_cols = 4; i_rd_pitch = 4;
            @(posedge clk); #1;
            i_start = 0;
            t = 0;
            while ((px_cnt - px0) < 2 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            chk("abort_reached_2px", 64'((px_cnt - px0) >= 2), 1);
            mon_en = 0;
            i_rst = 1;
            @(posedge clk); #1;
            i_rst = 0;
            @(negedge clk);
            chk("abort_busy", 64'(o_busy), 0);
            chk("abort_rd_en", 64'(o_bf_rd_en), 0);
            chk("abort_px_valid", 64'(o_px_valid), 0);
            chk("abort_px_last", 64'(o_px_last), 0);
            chk("abort_done", 64'(o_done), 0);
            repeat (20) begin
                @(negedge clk);
                chk("abort_quiet", 64'({o_px_valid, o_done, o_bf_rd_en}), 0);
            end
            exp_wa_q.delete(); exp_wd_q.delete();
            exp_ra_q.delete(); exp_px_q.delete();
            mon_en = 1;
        end
        build_model(8, 2, 2, 3, 3, 0);
        launch_job(8, 2, 2, 3, 3, 2, 0);

        // Full-depth load, then random jobs.
        build_model(DEPTH, 1000, 5, 5, 100, 0);
        launch_job(DEPTH, 1000, 5, 5, 100, 2, 0);
        for (int k = 0; k < 8; k++) begin
            int len, base, rows, cols, pitch, sm;
            len   = $urandom_range(0, 40);
            base  = $urandom_range(0, DEPTH - 1);
            rows  = $urandom_range(0, 6);
            cols  = $urandom_range(0, 6);
            pitch = $urandom_range(0, DEPTH - 1);
            sm    = $urandom_range(0, 2);
            build_model(len, base, rows, cols, pitch, 0);
            launch_job(len, base, rows, cols, pitch, sm, (sm == 0));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
